code_loader: RTL and testbench

- Boot and load sequencer for the processor datapath.
- Accepts a byte stream over a valid/ready handshake and assembles it into 16-bit instruction words.
- Writes the words into code memory through the datapath's code_w_en / code_addr_in / code_in write port, then asserts run to start execution.
- Sits between an external byte source (UART/host bridge) and the datapath top level. It is the only driver of run and of the code-memory write port.

---
 rtl/code_loader.sv | 159 +++++++++++++++
 tb/tb_code_loader.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/code_loader.sv
// code_loader: boot/load sequencer for the processor datapath.
// Receives a byte stream (16-bit word count, then the words, all high byte
// first) over a valid/ready handshake. Each assembled word is written into
// code memory, and run is raised once the whole program has been written.
//
// Ports:
//   clk, rst_n      clock, synchronous active-low reset
//   load_req        one-cycle request to start/restart a load
//   byte_in         stream byte
//   byte_valid      byte_in holds a valid byte
//   byte_ready      loader accepts a byte this cycle (receive states only)
//   code_w_en       code memory write enable
//   code_addr_in    code memory write address
//   code_in         code memory write data
//   run             processor run enable
//   busy            high during any load state
//   error           length-overflow error flag
//   words_loaded    words written in the current or last load
module code_loader #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned WORD_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_req,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              code_w_en,
  output logic [ADDR_W-1:0] code_addr_in,
  output logic [WORD_W-1:0] code_in,
  output logic              run,
  output logic              busy,
  output logic              error,
  output logic [ADDR_W:0]   words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA_HI,
    S_DATA_LO,
    S_WRITE,
    S_RUN,
    S_ERROR
  } state_t;

  // Largest legal word count: the full memory.
  localparam logic [16:0] MAX_LEN = 17'(1) << ADDR_W;

  state_t            state_q, state_d;
  logic [15:0]       len_q, len_d;
  logic [7:0]        hi_q, hi_d;
  logic [ADDR_W:0]   addr_q, addr_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              xfer;
  logic [15:0]       len_full;

  assign byte_ready = (state_q == S_LEN_HI)  || (state_q == S_LEN_LO) ||
                      (state_q == S_DATA_HI) || (state_q == S_DATA_LO);
  assign busy       = byte_ready || (state_q == S_WRITE);
  assign code_w_en  = (state_q == S_WRITE);
  assign run        = (state_q == S_RUN);
  assign error      = (state_q == S_ERROR);

  assign xfer     = byte_valid && byte_ready;
  assign len_full = {len_q[15:8], byte_in};

  // Write address/data are registered when the low byte arrives so they hold
  // their last values outside WRITE even after the address counter advances.
  assign code_addr_in = waddr_q;
  assign code_in      = wdata_q;
  assign words_loaded = words_q;

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    hi_d    = hi_q;
    addr_d  = addr_q;
    words_d = words_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    case (state_q)
      S_IDLE: begin
        if (load_req) state_d = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (xfer) begin
          len_d[15:8] = byte_in;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          len_d   = len_full;
          addr_d  = '0;
          words_d = '0;
          if (len_full == 16'd0) begin
            state_d = S_RUN;
          end else if ({1'b0, len_full} > MAX_LEN) begin
            state_d = S_ERROR;
          end else begin
            state_d = S_DATA_HI;
          end
        end
      end
      S_DATA_HI: begin
        if (xfer) begin
          hi_d    = byte_in;
          state_d = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (xfer) begin
          waddr_d = addr_q[ADDR_W-1:0];
          wdata_d = WORD_W'({hi_q, byte_in});
          state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + 1'b1;
        words_d = words_q + 1'b1;
        if (16'(words_q) + 16'd1 == len_q) begin
          state_d = S_RUN;
        end else begin
          state_d = S_DATA_HI;
        end
      end
      S_RUN, S_ERROR: begin
        if (load_req) state_d = S_LEN_HI;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      hi_q    <= '0;
      addr_q  <= '0;
      words_q <= '0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      hi_q    <= hi_d;
      addr_q  <= addr_d;
      words_q <= words_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

endmodule

// File: tb/tb_code_loader.sv
`timescale 1ns/1ps
module tb_code_loader;

  localparam int unsigned ADDR_W = 9;
  localparam int unsigned WORD_W = 16;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              load_req = 1'b0;
  logic [7:0]        byte_in = 8'h00;
  logic              byte_valid = 1'b0;
  logic              byte_ready;
  logic              code_w_en;
  logic [ADDR_W-1:0] code_addr_in;
  logic [WORD_W-1:0] code_in;
  logic              run;
  logic              busy;
  logic              error;
  logic [ADDR_W:0]   words_loaded;

  code_loader #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) dut (
    .clk(clk), .rst_n(rst_n), .load_req(load_req), .byte_in(byte_in),
    .byte_valid(byte_valid), .byte_ready(byte_ready), .code_w_en(code_w_en),
    .code_addr_in(code_addr_in), .code_in(code_in), .run(run), .busy(busy),
    .error(error), .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  typedef logic [7:0] bq_t[$];
  typedef struct { int unsigned addr; int unsigned data; } wr_t;
  typedef struct { bit is_err; int unsigned words; int unsigned lat; } out_t;

  wr_t  wr_q[$];
  out_t out_q[$];
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int unsigned last_xfer = 0;
  logic prev_run = 1'b0;
  logic prev_err = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: derives every write and the final outcome directly from
  // the byte stream (count first, then words), including truncated streams.
  task automatic model(input bq_t b);
    int unsigned len, nw;
    if (b.size() < 2) return;
    len = 32'({b[0], b[1]});
    if (len == 0) begin
      out_q.push_back('{is_err: 1'b0, words: 0, lat: 1});
    end else if (len > DEPTH) begin
      out_q.push_back('{is_err: 1'b1, words: 0, lat: 1});
    end else begin
      nw = (b.size() - 2) / 2;
      if (nw > len) nw = len;
      for (int unsigned i = 0; i < nw; i++)
        wr_q.push_back('{addr: i, data: 32'({b[2+2*i], b[3+2*i]})});
      if (b.size() >= 2 + 2 * len)
        out_q.push_back('{is_err: 1'b0, words: len, lat: 2});
    end
  endtask

  // Monitor/scoreboard: samples on the falling edge.
  always @(negedge clk) begin
    wr_t  w;
    out_t o;
    cyc++;
    if (rst_n) begin
      chk("run_with_wen", 64'(run & code_w_en), 64'(0));
      chk("ready_outside_busy", 64'(byte_ready & ~busy), 64'(0));
      if (byte_valid && byte_ready) last_xfer = cyc;
      if (code_w_en) begin
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h expected none", code_addr_in, code_in);
        end else begin
          w = wr_q.pop_front();
          chk("wr_addr", 64'(code_addr_in), 64'(w.addr));
          chk("wr_data", 64'(code_in), 64'(w.data));
        end
      end
      if ((run && !prev_run) || (error && !prev_err)) begin
        if (out_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_outcome: got run=%0d error=%0d expected none", run, error);
        end else begin
          o = out_q.pop_front();
          chk("outcome_error", 64'(error), 64'(o.is_err));
          chk("outcome_run", 64'(run), 64'(!o.is_err));
          chk("outcome_words", 64'(words_loaded), 64'(o.words));
          chk("outcome_latency", 64'(cyc - last_xfer), 64'(o.lat));
          chk("outcome_pending_writes", 64'(wr_q.size()), 64'(0));
        end
      end
    end
    prev_run = run;
    prev_err = error;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    @(negedge clk);
    chk({tag, "_run"}, 64'(run), 64'(0));
    chk({tag, "_wen"}, 64'(code_w_en), 64'(0));
    chk({tag, "_ready"}, 64'(byte_ready), 64'(0));
    chk({tag, "_busy"}, 64'(busy), 64'(0));
    chk({tag, "_error"}, 64'(error), 64'(0));
    chk({tag, "_addr"}, 64'(code_addr_in), 64'(0));
    chk({tag, "_data"}, 64'(code_in), 64'(0));
    chk({tag, "_words"}, 64'(words_loaded), 64'(0));
    tick();
  endtask

  // mode: 0 valid held, 1 valid toggling, 2 valid random.
  // noise: random load_req pulses while the load is in progress.
  task automatic send(input bq_t b, input int unsigned mode, input bit with_req, input bit noise);
    int unsigned idx, guard;
    bit acc;
    model(b);
    idx = 0;
    guard = 0;
    load_req = with_req;
    while (idx < b.size()) begin
      byte_in = b[idx];
      if (mode == 0)      byte_valid = 1'b1;
      else if (mode == 1) byte_valid = ~byte_valid;
      else                byte_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
      acc = byte_valid && byte_ready;
      tick();
      if (acc) begin
        idx++;
        guard = 0;
      end else begin
        guard++;
        if (guard > 50) begin
          $display("FAIL byte_accept_timeout: got no transfer for byte %0d expected transfer", idx);
          $fatal(1);
        end
      end
      load_req = noise && (idx < b.size()) && ($urandom_range(0, 3) == 0);
    end
    byte_valid = 1'b0;
    load_req = 1'b0;
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while ((wr_q.size() + out_q.size()) != 0 && n < 20) begin
      tick();
      n++;
    end
    chk("drain", 64'(wr_q.size() + out_q.size()), 64'(0));
  endtask

  initial begin
    bq_t b;
    int unsigned len;

    repeat (3) tick();
    rst_n = 1'b1;
    chk_idle("reset");

    b = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
    send(b, 0, 1'b1, 1'b0);
    drain();
    send(b, 1, 1'b1, 1'b0);
    drain();

    b = '{8'h00, 8'h00};
    send(b, 0, 1'b1, 1'b0);
    drain();

    b = '{8'h02, 8'h01};
    send(b, 0, 1'b1, 1'b0);
    drain();
    @(negedge clk);
    chk("err_hold_error", 64'(error), 64'(1));
    chk("err_hold_run", 64'(run), 64'(0));
    chk("err_hold_words", 64'(words_loaded), 64'(0));
    tick();

    b = '{8'h00, 8'h01, 8'hFF, 8'hFF};
    send(b, 0, 1'b1, 1'b0);
    drain();

    b = '{8'h02, 8'h00};
    for (int unsigned i = 0; i < DEPTH; i++) begin
      b.push_back(8'(i >> 8));
      b.push_back(8'(i));
    end
    send(b, 0, 1'b1, 1'b0);
    drain();

    for (int unsigned t = 0; t < 6; t++) begin
      len = $urandom_range(1, 8);
      b = '{8'h00, 8'(len)};
      for (int unsigned i = 0; i < 2 * len; i++) b.push_back(8'($urandom));
      send(b, $urandom_range(0, 2), 1'b1, 1'b1);
      drain();
    end

    // Abort a 4-word load after three data bytes; only word 0 gets written.
    b = '{8'h00, 8'h04, 8'h11, 8'h22, 8'h33};
    send(b, 0, 1'b1, 1'b0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk_idle("midreset");
    drain();
    b = '{8'h00, 8'h01, 8'h5A, 8'hA5};
    send(b, 2, 1'b1, 1'b0);
    drain();

    // Restart directly from RUN.
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
    @(negedge clk);
    chk("restart_run", 64'(run), 64'(0));
    chk("restart_busy", 64'(busy), 64'(1));
    tick();
    b = '{8'h00, 8'h01, 8'hC3, 8'h3C};
    send(b, 0, 1'b0, 1'b0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: got no completion expected finish within 1ms");
    $fatal(1);
  end

endmodule
